pong_game_ctrl: RTL and testbench

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

---
 rtl/pong_pkg.sv | 29 ++
 rtl/pong_paddle.sv | 40 ++++
 rtl/pong_game_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared game-state encoding, playfield geometry constants and default tuning values
// for the pong game controller and its paddle sub-block.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_POINT    = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_t;

  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_PADDLE_H    = 64;
  localparam int DEF_BALL_SZ     = 8;
  localparam int DEF_PADDLE_STEP = 4;
  localparam int DEF_BALL_SPEED  = 2;
  localparam int DEF_WIN_SCORE   = 7;
  localparam int DEF_SERVE_DELAY = 60;

  // Left paddle occupies x 16..23, so its face is column 24; the right paddle
  // mirrors it with its face at H_ACTIVE-PAD2_INSET.
  localparam int PADDLE_W   = 8;
  localparam int PAD1_X     = 16;
  localparam int PAD1_FACE  = PAD1_X + PADDLE_W;
  localparam int PAD2_INSET = 24;

endpackage

// File: rtl/pong_paddle.sv
// One paddle's vertical position: moves a fixed step per enabled update,
// saturating at the top and bottom of the visible area; opposing buttons cancel.
module pong_paddle
  import pong_pkg::*;
#(
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int PADDLE_H    = DEF_PADDLE_H,
  parameter int PADDLE_STEP = DEF_PADDLE_STEP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       dn,
  output logic [9:0] y
);

  localparam logic signed [10:0] Y_MAX = 11'(V_ACTIVE - PADDLE_H);
  localparam logic signed [10:0] Y_RST = 11'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic signed [10:0] STEP  = 11'(PADDLE_STEP);

  logic signed [10:0] pos;
  logic signed [10:0] pos_nx;

  always_comb begin
    pos_nx = pos;
    if (en && (up != dn)) begin
      if (up) pos_nx = (pos - STEP < 11'sd0) ? 11'sd0 : pos - STEP;
      else    pos_nx = (pos + STEP > Y_MAX) ? Y_MAX : pos + STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pos <= Y_RST;
    else     pos <= pos_nx;
  end

  assign y = pos[9:0];

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: serve/play/score state machine, ball motion with wall and
// paddle bounces, and two paddles, all advancing once per enabled frame tick.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int PADDLE_H    = DEF_PADDLE_H,
  parameter int BALL_SZ     = DEF_BALL_SZ,
  parameter int PADDLE_STEP = DEF_PADDLE_STEP,
  parameter int BALL_SPEED  = DEF_BALL_SPEED,
  parameter int WIN_SCORE   = DEF_WIN_SCORE,
  parameter int SERVE_DELAY = DEF_SERVE_DELAY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic       p1_up,
  input  logic       p1_dn,
  input  logic       p2_up,
  input  logic       p2_dn,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] pad1_y,
  output logic [9:0] pad2_y,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [2:0] state
);

  localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_DELAY - 1);
  localparam logic signed [10:0] X_CTR  = 11'((H_ACTIVE - BALL_SZ) / 2);
  localparam logic signed [10:0] Y_CTR  = 11'((V_ACTIVE - BALL_SZ) / 2);
  localparam logic signed [10:0] X_MAX  = 11'(H_ACTIVE - BALL_SZ);
  localparam logic signed [10:0] Y_MAX  = 11'(V_ACTIVE - BALL_SZ);
  localparam logic signed [10:0] FACE_L = 11'(PAD1_FACE);
  localparam logic signed [10:0] FACE_R = 11'(H_ACTIVE - PAD2_INSET);
  localparam logic signed [10:0] BSZ    = 11'(BALL_SZ);
  localparam logic signed [10:0] PH     = 11'(PADDLE_H);
  localparam logic signed [10:0] SPD    = 11'(BALL_SPEED);
  localparam logic [3:0]         WIN    = 4'(WIN_SCORE);

  state_t             cur_state, state_nx;
  logic signed [10:0] bx, by, bx_nx, by_nx, nx, ny;
  logic signed [10:0] pad1_s, pad2_s;
  logic               dx_neg, dy_neg, dx_nx, dy_nx;
  logic               p1_pt, p1_pt_nx;
  logic [3:0]         s1, s2, s1_nx, s2_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               upd, pad_en, hit_l, hit_r;

  assign upd    = clk_en && frame_tick;
  assign pad_en = upd && (cur_state != ST_GAMEOVER);
  assign pad1_s = {1'b0, pad1_y};
  assign pad2_s = {1'b0, pad2_y};
  assign nx     = dx_neg ? bx - SPD : bx + SPD;
  assign ny     = dy_neg ? by - SPD : by + SPD;

  // Paddle spans are taken before this update's paddle move is applied.
  assign hit_l = dx_neg && (bx >= FACE_L) && (nx <= FACE_L)
                 && (by < pad1_s + PH) && (by + BSZ > pad1_s);
  assign hit_r = !dx_neg && (bx + BSZ <= FACE_R) && (nx + BSZ >= FACE_R)
                 && (by < pad2_s + PH) && (by + BSZ > pad2_s);

  always_comb begin
    state_nx = cur_state;
    bx_nx    = bx;
    by_nx    = by;
    dx_nx    = dx_neg;
    dy_nx    = dy_neg;
    p1_pt_nx = p1_pt;
    s1_nx    = s1;
    s2_nx    = s2;
    cnt_nx   = cnt;
    case (cur_state)
      ST_IDLE: if (clk_en && serve) begin
        state_nx = ST_SERVE;
        cnt_nx   = '0;
        bx_nx    = X_CTR;
        by_nx    = Y_CTR;
      end
      ST_SERVE: begin
        bx_nx = X_CTR;
        by_nx = Y_CTR;
        if (upd) begin
          if (cnt == CNT_LAST) begin
            state_nx = ST_PLAY;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      ST_PLAY: if (upd) begin
        if (ny <= 11'sd0) begin
          by_nx = 11'sd0;
          dy_nx = 1'b0;
        end else if (ny >= Y_MAX) begin
          by_nx = Y_MAX;
          dy_nx = 1'b1;
        end else begin
          by_nx = ny;
        end
        if (hit_l) begin
          bx_nx = FACE_L;
          dx_nx = 1'b0;
        end else if (hit_r) begin
          bx_nx = FACE_R - BSZ;
          dx_nx = 1'b1;
        end else if (nx <= 11'sd0) begin
          bx_nx    = 11'sd0;
          s2_nx    = (s2 >= WIN) ? WIN : s2 + 4'd1;
          p1_pt_nx = 1'b0;
          state_nx = ST_POINT;
        end else if (nx >= X_MAX) begin
          bx_nx    = X_MAX;
          s1_nx    = (s1 >= WIN) ? WIN : s1 + 4'd1;
          p1_pt_nx = 1'b1;
          state_nx = ST_POINT;
        end else begin
          bx_nx = nx;
        end
      end
      ST_POINT: if (upd) begin
        if ((p1_pt ? s1 : s2) >= WIN) begin
          state_nx = ST_GAMEOVER;
        end else begin
          // Serve travels toward the player who just lost the point.
          state_nx = ST_SERVE;
          cnt_nx   = '0;
          bx_nx    = X_CTR;
          by_nx    = Y_CTR;
          dx_nx    = !p1_pt;
        end
      end
      ST_GAMEOVER: if (clk_en && serve) begin
        state_nx = ST_SERVE;
        cnt_nx   = '0;
        bx_nx    = X_CTR;
        by_nx    = Y_CTR;
        s1_nx    = '0;
        s2_nx    = '0;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= ST_IDLE;
      bx        <= X_CTR;
      by        <= Y_CTR;
      dx_neg    <= 1'b0;
      dy_neg    <= 1'b0;
      p1_pt     <= 1'b0;
      s1        <= '0;
      s2        <= '0;
      cnt       <= '0;
    end else begin
      cur_state <= state_nx;
      bx        <= bx_nx;
      by        <= by_nx;
      dx_neg    <= dx_nx;
      dy_neg    <= dy_nx;
      p1_pt     <= p1_pt_nx;
      s1        <= s1_nx;
      s2        <= s2_nx;
      cnt       <= cnt_nx;
    end
  end

  pong_paddle #(.V_ACTIVE(V_ACTIVE), .PADDLE_H(PADDLE_H), .PADDLE_STEP(PADDLE_STEP)) u_pad1 (
    .clk(clk), .rst(rst), .en(pad_en), .up(p1_up), .dn(p1_dn), .y(pad1_y)
  );

  pong_paddle #(.V_ACTIVE(V_ACTIVE), .PADDLE_H(PADDLE_H), .PADDLE_STEP(PADDLE_STEP)) u_pad2 (
    .clk(clk), .rst(rst), .en(pad_en), .up(p2_up), .dn(p2_dn), .y(pad2_y)
  );

  assign ball_x = bx[9:0];
  assign ball_y = by[9:0];
  assign score1 = s1;
  assign score2 = s2;
  assign state  = cur_state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl at default parameters; trajectories are hand-derived
// from the centre serve (316,236), speed 2, walls at y=0/472, paddle faces at x=24/616.
module tb_pong_game_ctrl;

  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4;

  logic       clk, rst, clk_en, frame_tick, serve;
  logic       p1_up, p1_dn, p2_up, p2_dn;
  logic [9:0] ball_x, ball_y, pad1_y, pad2_y;
  logic [3:0] score1, score2;
  logic [2:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  pong_game_ctrl dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .frame_tick(frame_tick), .serve(serve),
    .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
    .ball_x(ball_x), .ball_y(ball_y), .pad1_y(pad1_y), .pad2_y(pad2_y),
    .score1(score1), .score2(score2), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // One update; returns on a falling edge with outputs settled.
  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic serve_pulse();
    @(negedge clk);
    serve = 1'b1;
    @(negedge clk);
    serve = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, state, S_IDLE);
    check({tag, "_ball_x"}, ball_x, 316);
    check({tag, "_ball_y"}, ball_y, 236);
    check({tag, "_pad1"}, pad1_y, 208);
    check({tag, "_pad2"}, pad2_y, 208);
    check({tag, "_score1"}, score1, 0);
    check({tag, "_score2"}, score2, 0);
  endtask

  initial begin
    int e;
    rst = 1'b1; clk_en = 1'b1; frame_tick = 1'b0; serve = 1'b0;
    p1_up = 1'b0; p1_dn = 1'b0; p2_up = 1'b0; p2_dn = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_vals("reset");

    // Paddle saturation and cancelling, exercised while idle.
    p1_up = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      e = 208 - 4 * i;
      if (e < 0) e = 0;
      check("pad1_up_sat", pad1_y, e);
    end
    p1_up = 1'b0;
    p2_up = 1'b1; p2_dn = 1'b1;
    ticks(5);
    check("pad2_both", pad2_y, 208);
    p2_up = 1'b0;
    ticks(60);
    check("pad2_dn_sat", pad2_y, 416);
    p2_dn = 1'b0;
    check("idle_holds", state, S_IDLE);

    // Reset must act even with the clock enable low.
    @(negedge clk);
    rst = 1'b1; clk_en = 1'b0;
    @(negedge clk);
    rst = 1'b0; clk_en = 1'b1;
    check_reset_vals("reset_noen");

    clk_en = 1'b0;
    serve_pulse();
    check("serve_noen", state, S_IDLE);
    clk_en = 1'b1;
    serve_pulse();
    check("serve_start", state, S_SERVE);
    ticks(59);
    check("serve_59", state, S_SERVE);
    tick();
    check("play_state", state, S_PLAY);
    check("play_bx", ball_x, 316);
    check("play_by", ball_y, 236);
    check("play_pad1", pad1_y, 208);
    check("play_pad2", pad2_y, 208);

    // Rally 1: dx+, dy+, right paddle driven to the top, ball misses low on the right.
    clk_en = 1'b0;
    tick();
    clk_en = 1'b1;
    check("noen_bx", ball_x, 316);
    p2_up = 1'b1;
    for (int k = 1; k <= 158; k++) begin
      tick();
      if (k == 1) begin
        check("r1_k1_bx", ball_x, 318);
        check("r1_k1_by", ball_y, 238);
      end
      if (k == 10) begin
        serve_pulse();
        check("serve_in_play", state, S_PLAY);
      end
      if (k == 118) check("r1_bottom", ball_y, 472);
      if (k == 119) check("r1_bottom_up", ball_y, 470);
      if (k == 157) check("r1_k157", state, S_PLAY);
      if (k == 158) begin
        check("r1_point", state, S_POINT);
        check("r1_score1", score1, 1);
        check("r1_score2", score2, 0);
        check("r1_bx", ball_x, 632);
        check("r1_by", ball_y, 392);
      end
    end
    p2_up = 1'b0;
    tick();
    check("r1_serve", state, S_SERVE);
    check("r1_ctr_x", ball_x, 316);
    check("r1_pad2", pad2_y, 0);

    // Rally 2: serve heads toward P2 (x increasing), dy-, top wall bounce.
    p2_dn = 1'b1;
    ticks(60);
    p2_dn = 1'b0;
    check("r2_play", state, S_PLAY);
    check("r2_pad2", pad2_y, 240);
    for (int k = 1; k <= 158; k++) begin
      tick();
      if (k == 1) begin
        check("r2_dx_toward_p2", ball_x, 318);
        check("r2_k1_by", ball_y, 234);
      end
      if (k == 118) check("r2_top", ball_y, 0);
      if (k == 119) check("r2_top_down", ball_y, 2);
      if (k == 158) check("r2_score1", score1, 2);
    end
    tick();
    check("r2_serve", state, S_SERVE);

    // Rallies 3..7: pad2 at 240 misses both trajectories; P1 wins the game.
    for (int r = 3; r <= 7; r++) begin
      ticks(60);
      check("rn_play", state, S_PLAY);
      ticks(158);
      check("rn_point", state, S_POINT);
      check("rn_score1", score1, r);
      tick();
      if (r < 7) check("rn_serve", state, S_SERVE);
    end
    check("gameover", state, S_OVER);
    check("go_score1", score1, 7);
    check("go_score2", score2, 0);
    p1_dn = 1'b1;
    ticks(3);
    p1_dn = 1'b0;
    check("go_pad_frozen", pad1_y, 208);
    check("go_holds", state, S_OVER);
    serve_pulse();
    check("restart_state", state, S_SERVE);
    check("restart_s1", score1, 0);
    check("restart_s2", score2, 0);
    check("restart_bx", ball_x, 316);

    // Rally 8: dy-, pad2 driven to 0 so the ball hits the right paddle at k=146.
    p2_up = 1'b1; p1_up = 1'b1;
    ticks(60);
    p2_up = 1'b0; p1_up = 1'b0;
    check("r8_play", state, S_PLAY);
    check("r8_pad2", pad2_y, 0);
    check("r8_pad1", pad1_y, 0);
    for (int k = 1; k <= 147; k++) begin
      tick();
      if (k == 146) begin
        check("hit_bx", ball_x, 608);
        check("hit_by", ball_y, 56);
      end
      if (k == 147) begin
        check("hit_rebound_bx", ball_x, 606);
        check("hit_state", state, S_PLAY);
      end
    end

    // Reset coincident with a frame tick in mid-play.
    @(negedge clk);
    rst = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    rst = 1'b0; frame_tick = 1'b0;
    check_reset_vals("reset_midplay");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
